mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk_in  in  1  system clock; all state updates on rising edge.
REQ-002 rst_in  in  1  reset, synchronous, active-low.
REQ-003 rdy_in  in  1  global enable; low freezes all state.
REQ-004 _clear  in  1  branch-mispredict flush.
REQ-005 _if_req  in  1; _if_addr  in  32  instruction-fetch read request and byte address.
REQ-006 _if_ready  out  1; _if_data  out  32  one-cycle fetch-complete pulse and little-endian word.
REQ-007 _lsb_req  in  1; _lsb_wr  in  1; _lsb_size  in  2 (0=byte, 1=half, 2=word); _lsb_addr  in  32; _lsb_wdata  in  32  load/store request.
REQ-008 _lsb_ready  out  1; _lsb_rdata  out  32  one-cycle completion pulse; load data zero-extended.
REQ-009 _mem_busy  out  1  high whenever FSM is not IDLE.
REQ-010 mem_din  in  8; mem_dout  out  8; mem_a  out  32; mem_wr  out  1  byte-wide RAM port; read data valid one cycle after address.
REQ-011 io_buffer_full  in  1  UART buffer full; stalls writes to I/O space (addr[17:16]==2'b11).

Function
REQ-012 FSM states: IDLE, IF_RD, LS_RD, LS_WR.
REQ-013 In IDLE, _lsb_req wins over _if_req; the loser holds its request, and its inputs stay stable until its ready pulse.
REQ-014 Grant latches addr, size, and wdata. Byte count N = 4 for IF, and 1/2/4 from _lsb_size for LSB.
REQ-015 Read: in the k-th cycle after grant (k=1..N), mem_a=addr+k-1 and mem_wr=0. The byte on mem_din in cycle k+1 fills data bits [8(k-1)+7:8(k-1)].
REQ-016 Read: ready pulses in cycle N+2 after grant, with data valid in that cycle; the FSM returns to IDLE the same cycle.
REQ-017 Write: in cycles k=1..N, mem_a=addr+k-1, mem_dout=wdata byte k-1, mem_wr=1. _lsb_ready pulses in cycle N+1.
REQ-018 I/O write stall: if io_buffer_full=1 while a write byte targets I/O space, drive mem_wr=0 and hold the byte counter until io_buffer_full=0.
REQ-019 mem_wr=0 in every cycle that is not an active write byte, including IDLE and all read states.
REQ-020 _clear in IF_RD or LS_RD: abort next edge, go to IDLE, suppress ready.
REQ-021 _clear in LS_WR: ignored; the committed store completes.
REQ-022 _clear in IDLE: blocks grant that cycle.
REQ-023 A new grant is possible in the cycle after a ready pulse (no back-to-back grant in the same cycle).
REQ-024 rdy_in=0: FSM, counter, and latches hold; mem_wr forced 0; ready outputs 0.
REQ-025 Address arithmetic is 32-bit modulo 2^32; wrap at 0xFFFFFFFF continues at 0.

Reset
REQ-026 rst_in=0 at an edge: state=IDLE, counter=0, _if_ready=0, _lsb_ready=0, _if_data=0, _lsb_rdata=0, mem_a=0, mem_dout=0, mem_wr=0, _mem_busy=0.
REQ-027 Reset mid-transfer aborts the transfer with no ready pulse; a partial write leaves already-written bytes in RAM.

Structure
REQ-028 FSM state encodings, size codes, and the I/O address-decode constant live in the shared CPU definitions package.
REQ-029 One sub-module, mem_byte_seq: byte counter plus address/data lane sequencer shared by all transfer states.

Verification
REQ-030 IF read at 0x00000064 (RAM 0x13,0x05,0x00,0x00) -> _if_ready pulses in cycle 6 after grant, _if_data=0x00000513.
REQ-031 _if_req and _lsb_req (lb, 0x1000) in same cycle -> LSB granted first; _lsb_ready in cycle 3; IF grant follows and its data is correct.
REQ-032 sw 0xDEADBEEF at 0x200 -> mem_wr=1 for 4 cycles; bytes EF, BE, AD, DE at 0x200..0x203; _lsb_ready in cycle 5.
REQ-033 _clear in cycle 3 of an IF read -> no _if_ready, IDLE next cycle; a sh issued concurrently with _clear still completes.
REQ-034 sb to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then the write is issued; _lsb_ready is delayed by 3 cycles.
REQ-035 rst_in low during byte 2 of a word load -> all outputs reach their reset values next edge; no _lsb_ready is produced.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared CPU memory-controller definitions: FSM states, size codes, I/O decode
// and the request payload handed from the arbiter to the byte sequencer.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IF_RD = 2'd1,
        S_LS_RD = 2'd2,
        S_LS_WR = 2'd3
    } mem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // addr[17:16] == IO_SEL selects the UART-backed I/O window
    localparam logic [1:0] IO_SEL = 2'b11;

    typedef struct packed {
        logic              wr;
        logic [CNT_W-1:0]  n;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic [CNT_W-1:0] size_to_n(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return CNT_W'(1);
            SIZE_HALF: return CNT_W'(2);
            SIZE_WORD: return CNT_W'(4);
            default:   return CNT_W'(4);
        endcase
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] addr);
        return addr[17:16] == IO_SEL;
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte counter and address/data lane sequencer for the byte-wide RAM port,
// shared by instruction fetch, loads and stores.
module mem_byte_seq
    import mem_ctrl_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              en,
    input  logic              load,
    input  mem_req_t          req,
    input  logic              run_rd,
    input  logic              run_wr,
    input  logic              io_buffer_full,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic [BYTE_W-1:0] mem_dout,
    output logic              mem_wr,
    output logic              rd_last_c,
    output logic [DATA_W-1:0] rd_word_c,
    output logic              wr_done_c
);

    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LANE_W-1:0] a_idx_q;
    logic              a_rd_q;
    logic [LANE_W-1:0] cap_idx_q;
    logic              cap_vld_q;

    logic [ADDR_W-1:0] cur_base;
    logic [DATA_W-1:0] cur_wdata;
    logic [CNT_W-1:0]  cur_n;
    logic [CNT_W-1:0]  cur_cnt;
    logic [ADDR_W-1:0] byte_addr;
    logic [BYTE_W-1:0] wr_byte;
    logic              is_wr;
    logic              pending;
    logic              issue;

    // On the grant cycle the new request is sequenced straight from the inputs
    always_comb begin
        cur_base  = load ? req.addr  : base_q;
        cur_wdata = load ? req.wdata : wdata_q;
        cur_n     = load ? req.n     : n_q;
        cur_cnt   = load ? '0        : cnt_q;
        is_wr     = load ? req.wr    : run_wr;
        byte_addr = cur_base + ADDR_W'(cur_cnt);
        pending   = (load || run_rd || run_wr) && (cur_cnt < cur_n);
        issue     = pending && !(is_wr && is_io(byte_addr) && io_buffer_full);
        wr_byte   = cur_wdata[{cur_cnt[LANE_W-1:0], 3'b000} +: BYTE_W];
    end

    // mem_din always reflects the address presented one cycle earlier (cap_*)
    always_comb begin
        rd_word_c = acc_q;
        rd_word_c[{cap_idx_q, 3'b000} +: BYTE_W] = mem_din;
        rd_last_c = cap_vld_q && ((CNT_W'(cap_idx_q) + CNT_W'(1)) == n_q);
        wr_done_c = (cnt_q == n_q);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            base_q    <= '0;
            wdata_q   <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            a_idx_q   <= '0;
            a_rd_q    <= 1'b0;
            cap_idx_q <= '0;
            cap_vld_q <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
        end else begin
            cap_idx_q <= a_idx_q;
            cap_vld_q <= a_rd_q;
            if (en) begin
                mem_wr <= issue && is_wr;
                cnt_q  <= issue ? cur_cnt + CNT_W'(1) : cur_cnt;
                if (load) begin
                    base_q  <= req.addr;
                    wdata_q <= req.wdata;
                    n_q     <= req.n;
                    acc_q   <= '0;
                end else if (run_rd && cap_vld_q) begin
                    acc_q <= rd_word_c;
                end
                if (pending) begin
                    mem_a   <= byte_addr;
                    a_idx_q <= cur_cnt[LANE_W-1:0];
                    a_rd_q  <= !is_wr;
                end else if (!run_rd) begin
                    a_rd_q <= 1'b0;
                end
                if (issue && is_wr) begin
                    mem_dout <= wr_byte;
                end
            end else begin
                mem_wr <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch and load/store requests onto
// a byte-wide RAM port, with flush, global stall and UART back-pressure.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              _clear,
    input  logic              _if_req,
    input  logic [ADDR_W-1:0] _if_addr,
    output logic              _if_ready,
    output logic [DATA_W-1:0] _if_data,
    input  logic              _lsb_req,
    input  logic              _lsb_wr,
    input  logic [1:0]        _lsb_size,
    input  logic [ADDR_W-1:0] _lsb_addr,
    input  logic [DATA_W-1:0] _lsb_wdata,
    output logic              _lsb_ready,
    output logic [DATA_W-1:0] _lsb_rdata,
    output logic              _mem_busy,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [BYTE_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    mem_state_e        state_q, state_d;
    logic              if_ready_d, lsb_ready_d;
    logic [DATA_W-1:0] if_data_d, lsb_rdata_d;
    logic              load, run_rd, run_wr;
    mem_req_t          req;
    logic              rd_last_c, wr_done_c;
    logic [DATA_W-1:0] rd_word_c;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            _if_ready  <= 1'b0;
            _lsb_ready <= 1'b0;
            _if_data   <= '0;
            _lsb_rdata <= '0;
            _mem_busy  <= 1'b0;
        end else begin
            state_q    <= state_d;
            _if_ready  <= if_ready_d;
            _lsb_ready <= lsb_ready_d;
            _if_data   <= if_data_d;
            _lsb_rdata <= lsb_rdata_d;
            _mem_busy  <= (state_d != S_IDLE);
        end
    end

    // A ready pulse in flight blocks grant so a requester's stale request is not re-taken
    always_comb begin
        state_d     = state_q;
        if_ready_d  = 1'b0;
        lsb_ready_d = 1'b0;
        if_data_d   = _if_data;
        lsb_rdata_d = _lsb_rdata;
        load        = 1'b0;
        run_rd      = 1'b0;
        run_wr      = 1'b0;
        req         = '0;
        if (rdy_in) begin
            case (state_q)
                S_IDLE: begin
                    if (!_clear && !_if_ready && !_lsb_ready) begin
                        if (_lsb_req) begin
                            load      = 1'b1;
                            req.wr    = _lsb_wr;
                            req.n     = size_to_n(_lsb_size);
                            req.addr  = _lsb_addr;
                            req.wdata = _lsb_wdata;
                            state_d   = _lsb_wr ? S_LS_WR : S_LS_RD;
                        end else if (_if_req) begin
                            load     = 1'b1;
                            req.n    = CNT_W'(4);
                            req.addr = _if_addr;
                            state_d  = S_IF_RD;
                        end
                    end
                end
                S_IF_RD: begin
                    if (_clear) begin
                        state_d = S_IDLE;
                    end else begin
                        run_rd = 1'b1;
                        if (rd_last_c) begin
                            if_ready_d = 1'b1;
                            if_data_d  = rd_word_c;
                            state_d    = S_IDLE;
                        end
                    end
                end
                S_LS_RD: begin
                    if (_clear) begin
                        state_d = S_IDLE;
                    end else begin
                        run_rd = 1'b1;
                        if (rd_last_c) begin
                            lsb_ready_d = 1'b1;
                            lsb_rdata_d = rd_word_c;
                            state_d     = S_IDLE;
                        end
                    end
                end
                S_LS_WR: begin
                    run_wr = 1'b1;
                    if (wr_done_c) begin
                        lsb_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    mem_byte_seq u_seq (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .en             (rdy_in),
        .load           (load),
        .req            (req),
        .run_rd         (run_rd),
        .run_wr         (run_wr),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .rd_last_c      (rd_last_c),
        .rd_word_c      (rd_word_c),
        .wr_done_c      (wr_done_c)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a byte-wide RAM model with one-cycle read latency.
module tb_mem_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _if_req;
    logic [31:0] _if_addr;
    logic        _if_ready;
    logic [31:0] _if_data;
    logic        _lsb_req;
    logic        _lsb_wr;
    logic [1:0]  _lsb_size;
    logic [31:0] _lsb_addr;
    logic [31:0] _lsb_wdata;
    logic        _lsb_ready;
    logic [31:0] _lsb_rdata;
    logic        _mem_busy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    bit [7:0] ram [0:262143];
    int vectors = 0;
    int errors  = 0;

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._if_req        (_if_req),
        ._if_addr       (_if_addr),
        ._if_ready      (_if_ready),
        ._if_data       (_if_data),
        ._lsb_req       (_lsb_req),
        ._lsb_wr        (_lsb_wr),
        ._lsb_size      (_lsb_size),
        ._lsb_addr      (_lsb_addr),
        ._lsb_wdata     (_lsb_wdata),
        ._lsb_ready     (_lsb_ready),
        ._lsb_rdata     (_lsb_rdata),
        ._mem_busy      (_mem_busy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // RAM model; image is (re)loaded while reset is held
    always @(posedge clk_in) begin
        if (!rst_in) begin
            ram[18'h00064] <= 8'h13;
            ram[18'h00065] <= 8'h05;
            ram[18'h00066] <= 8'h00;
            ram[18'h00067] <= 8'h00;
            ram[18'h01000] <= 8'hA5;
            ram[18'h3FFFE] <= 8'h11;
            ram[18'h3FFFF] <= 8'h22;
            ram[18'h00000] <= 8'h33;
            ram[18'h00001] <= 8'h44;
        end else if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] sw_data;
        sw_data        = 32'hDEADBEEF;
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        _clear         = 1'b0;
        _if_req        = 1'b0;
        _if_addr       = '0;
        _lsb_req       = 1'b0;
        _lsb_wr        = 1'b0;
        _lsb_size      = 2'd0;
        _lsb_addr      = '0;
        _lsb_wdata     = '0;
        io_buffer_full = 1'b0;
        tick();
        tick();
        check("rst_ctl", 32'({_if_ready, _lsb_ready, mem_wr, _mem_busy}), 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_dout", 32'(mem_dout), 32'h0);
        rst_in = 1'b1;
        tick();

        // IF read at 0x64
        _if_req  = 1'b1;
        _if_addr = 32'h64;
        tick();
        check("if_a1", mem_a, 32'h64);
        check("if_busy", 32'(_mem_busy), 32'h1);
        tick();
        check("if_a2", mem_a, 32'h65);
        tick();
        tick();
        check("if_a4", mem_a, 32'h67);
        check("if_nowr", 32'(mem_wr), 32'h0);
        tick();
        check("if_rdy5", 32'(_if_ready), 32'h0);
        tick();
        check("if_rdy6", 32'(_if_ready), 32'h1);
        check("if_data", _if_data, 32'h00000513);
        check("if_idle6", 32'(_mem_busy), 32'h0);
        _if_req = 1'b0;
        tick();
        check("if_pulse", 32'(_if_ready), 32'h0);

        // simultaneous lb 0x1000 and IF 0x64: LSB first
        _lsb_req  = 1'b1;
        _lsb_wr   = 1'b0;
        _lsb_size = 2'd0;
        _lsb_addr = 32'h1000;
        _if_req   = 1'b1;
        _if_addr  = 32'h64;
        tick();
        check("arb_a1", mem_a, 32'h1000);
        tick();
        tick();
        check("lb_rdy3", 32'(_lsb_ready), 32'h1);
        check("lb_data", _lsb_rdata, 32'h000000A5);
        check("arb_if_wait", 32'(_if_ready), 32'h0);
        _lsb_req = 1'b0;
        tick();
        check("arb_gap", 32'(_mem_busy), 32'h0);
        tick();
        check("arb_if_a", mem_a, 32'h64);
        repeat (5) tick();
        check("arb_if_rdy", 32'(_if_ready), 32'h1);
        check("arb_if_data", _if_data, 32'h00000513);
        _if_req = 1'b0;
        tick();

        // sw 0xDEADBEEF at 0x200
        _lsb_req   = 1'b1;
        _lsb_wr    = 1'b1;
        _lsb_size  = 2'd2;
        _lsb_addr  = 32'h200;
        _lsb_wdata = sw_data;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("sw_wr", 32'(mem_wr), 32'h1);
            check("sw_a", mem_a, 32'h200 + 32'(k - 1));
            check("sw_dout", 32'(mem_dout), 32'(sw_data[8*(k-1) +: 8]));
        end
        tick();
        check("sw_rdy5", 32'(_lsb_ready), 32'h1);
        check("sw_wr5", 32'(mem_wr), 32'h0);
        check("sw_ram", {ram[18'h203], ram[18'h202], ram[18'h201], ram[18'h200]}, 32'hDEADBEEF);
        _lsb_req = 1'b0;
        tick();

        // flush in cycle 3 of an IF read, sh issued alongside
        _if_req  = 1'b1;
        _if_addr = 32'h64;
        tick();
        tick();
        tick();
        _clear     = 1'b1;
        _if_req    = 1'b0;
        _lsb_req   = 1'b1;
        _lsb_wr    = 1'b1;
        _lsb_size  = 2'd1;
        _lsb_addr  = 32'h300;
        _lsb_wdata = 32'h0000CAFE;
        tick();
        check("clr_idle", 32'(_mem_busy), 32'h0);
        check("clr_nordy", 32'(_if_ready), 32'h0);
        _clear = 1'b0;
        tick();
        check("sh_b0", {mem_wr, 15'h0, mem_a[7:0], mem_dout}, {1'b1, 15'h0, 8'h00, 8'hFE});
        tick();
        check("sh_b1", {mem_wr, 15'h0, mem_a[7:0], mem_dout}, {1'b1, 15'h0, 8'h01, 8'hCA});
        check("clr_if_c6", 32'(_if_ready), 32'h0);
        tick();
        check("sh_rdy", 32'(_lsb_ready), 32'h1);
        check("sh_ram", 32'({ram[18'h301], ram[18'h300]}), 32'h0000CAFE);
        _lsb_req = 1'b0;
        tick();

        // sb to I/O space with UART buffer full for 3 cycles
        _lsb_req       = 1'b1;
        _lsb_wr        = 1'b1;
        _lsb_size      = 2'd0;
        _lsb_addr      = 32'h30000;
        _lsb_wdata     = 32'h0000005A;
        io_buffer_full = 1'b1;
        tick();
        check("io_stall1", 32'(mem_wr), 32'h0);
        tick();
        check("io_stall2", 32'(mem_wr), 32'h0);
        check("io_nordy2", 32'(_lsb_ready), 32'h0);
        tick();
        check("io_stall3", 32'(mem_wr), 32'h0);
        io_buffer_full = 1'b0;
        tick();
        check("io_wr", {mem_wr, 7'h0, mem_a[23:0]}, {1'b1, 7'h0, 24'h030000});
        check("io_dout", 32'(mem_dout), 32'h5A);
        tick();
        check("io_rdy", 32'(_lsb_ready), 32'h1);
        check("io_ram", 32'(ram[18'h30000]), 32'h5A);
        _lsb_req = 1'b0;
        tick();

        // lh at 0x64 with a one-cycle global stall
        _lsb_req  = 1'b1;
        _lsb_wr   = 1'b0;
        _lsb_size = 2'd1;
        _lsb_addr = 32'h64;
        tick();
        check("stl_a1", mem_a, 32'h64);
        rdy_in = 1'b0;
        tick();
        check("stl_hold", mem_a, 32'h64);
        rdy_in = 1'b1;
        tick();
        check("stl_a2", mem_a, 32'h65);
        tick();
        check("stl_nordy", 32'(_lsb_ready), 32'h0);
        tick();
        check("stl_rdy", 32'(_lsb_ready), 32'h1);
        check("stl_data", _lsb_rdata, 32'h00000513);
        _lsb_req = 1'b0;
        tick();

        // IF read wrapping past 0xFFFFFFFF
        _if_req  = 1'b1;
        _if_addr = 32'hFFFFFFFE;
        tick();
        tick();
        check("wrap_a2", mem_a, 32'hFFFFFFFF);
        tick();
        check("wrap_a3", mem_a, 32'h0);
        tick();
        tick();
        tick();
        check("wrap_rdy", 32'(_if_ready), 32'h1);
        check("wrap_data", _if_data, 32'h44332211);
        _if_req = 1'b0;
        tick();

        // reset during byte 2 of a word load
        _lsb_req  = 1'b1;
        _lsb_wr   = 1'b0;
        _lsb_size = 2'd2;
        _lsb_addr = 32'h64;
        tick();
        tick();
        check("rl_a2", mem_a, 32'h65);
        rst_in = 1'b0;
        tick();
        check("rl_ctl", 32'({_if_ready, _lsb_ready, mem_wr, _mem_busy}), 32'h0);
        check("rl_mem_a", mem_a, 32'h0);
        check("rl_dout", 32'(mem_dout), 32'h0);
        check("rl_if_data", _if_data, 32'h0);
        check("rl_lsb_rdata", _lsb_rdata, 32'h0);
        rst_in   = 1'b1;
        _lsb_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rl_nordy", 32'({_lsb_ready, _mem_busy}), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
